// File: rtl/mic_frame_reader.sv
// Mailbox consumer for microphone frames: polls the flag word, streams packed
// 16-bit PCM samples out on Avalon-ST, then clears the flag to release the producer.
module mic_frame_reader #(
  parameter int MIC_N     = 2,
  parameter int ADDR_W    = 10,
  parameter int ADDR_LAST = 1023,
  localparam int CH_W     = (MIC_N > 2) ? $clog2(MIC_N) : 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              irq_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  output logic [3:0]        ram_byteenable,
  input  logic [31:0]       ram_readdata,
  output logic [15:0]       av_st_out_data,
  output logic              av_st_out_valid,
  input  logic              av_st_out_ready,
  output logic              av_st_out_startofpacket,
  output logic              av_st_out_endofpacket,
  output logic [CH_W-1:0]   av_st_out_channel,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int W = (MIC_N + 1) / 2;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(ADDR_LAST);

  typedef enum logic [3:0] {
    IDLE, POLL_REQ, POLL_CHK, RD_REQ, RD_CAP, EMIT_LO, EMIT_HI, RELEASE, DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       hold_reg, hold_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [15:0]       fc_reg, fc_next;

  logic lo_last, hi_last, hi_eop;

  // Frame-boundary decodes on the current word index
  assign lo_last = (32'(idx_reg) * 32'd2 + 32'd1) == 32'(MIC_N);
  assign hi_eop  = (32'(idx_reg) * 32'd2 + 32'd2) == 32'(MIC_N);
  assign hi_last = 32'(idx_reg) == 32'(W - 1);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      hold_reg  <= '0;
      wdata_reg <= '0;
      fc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      addr_reg  <= addr_next;
      hold_reg  <= hold_next;
      wdata_reg <= wdata_next;
      fc_reg    <= fc_next;
    end
  end

  always_comb begin
    state_next              = state_reg;
    idx_next                = idx_reg;
    addr_next               = addr_reg;
    hold_next               = hold_reg;
    wdata_next              = wdata_reg;
    fc_next                 = fc_reg;
    ram_chipselect          = 1'b0;
    ram_write               = 1'b0;
    av_st_out_valid         = 1'b0;
    av_st_out_data          = '0;
    av_st_out_channel       = '0;
    av_st_out_startofpacket = 1'b0;
    av_st_out_endofpacket   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (irq_in) begin
          addr_next  = FLAG_ADDR;
          state_next = POLL_REQ;
        end
      end
      POLL_REQ: begin
        ram_chipselect = 1'b1;
        state_next     = POLL_CHK;
      end
      POLL_CHK: begin
        // A zero flag means the interrupt did not announce a frame
        if (ram_readdata == 32'd0) begin
          state_next = IDLE;
        end else begin
          idx_next   = '0;
          addr_next  = '0;
          state_next = RD_REQ;
        end
      end
      RD_REQ: begin
        ram_chipselect = 1'b1;
        state_next     = RD_CAP;
      end
      RD_CAP: begin
        hold_next  = ram_readdata;
        state_next = EMIT_LO;
      end
      EMIT_LO: begin
        av_st_out_valid         = 1'b1;
        av_st_out_data          = hold_reg[15:0];
        av_st_out_channel       = CH_W'({idx_reg, 1'b0});
        av_st_out_startofpacket = (idx_reg == '0);
        av_st_out_endofpacket   = lo_last;
        if (av_st_out_ready) begin
          if (lo_last) begin
            addr_next  = FLAG_ADDR;
            wdata_next = '0;
            state_next = RELEASE;
          end else begin
            state_next = EMIT_HI;
          end
        end
      end
      EMIT_HI: begin
        av_st_out_valid       = 1'b1;
        av_st_out_data        = hold_reg[31:16];
        av_st_out_channel     = CH_W'({idx_reg, 1'b1});
        av_st_out_endofpacket = hi_eop;
        if (av_st_out_ready) begin
          if (hi_last) begin
            addr_next  = FLAG_ADDR;
            wdata_next = '0;
            state_next = RELEASE;
          end else begin
            idx_next   = idx_reg + ADDR_W'(1);
            addr_next  = idx_reg + ADDR_W'(1);
            state_next = RD_REQ;
          end
        end
      end
      RELEASE: begin
        ram_chipselect = 1'b1;
        ram_write      = 1'b1;
        state_next     = DONE;
      end
      DONE: begin
        fc_next    = fc_reg + 16'd1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign ram_address    = addr_reg;
  assign ram_writedata  = wdata_reg;
  assign ram_byteenable = 4'b1111;
  assign frame_count    = fc_reg;
  assign busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_mic_frame_reader.sv
// Self-checking bench for mic_frame_reader: three instances (MIC_N = 2, 3, 4) with
// a RAM model, directed and randomized frames scored against a frame-layout model.
module tb_mic_frame_reader;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  ch;
    logic        sop;
    logic        eop;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int N   = gi + 2;
    localparam int NW  = (N + 1) / 2;
    localparam int CHW = (N > 2) ? $clog2(N) : 1;

    logic            rst_n = 1'b1;
    logic            irq = 1'b0;
    logic            ready = 1'b1;
    logic [9:0]      addr;
    logic            cs, wr;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic [31:0]     rdata;
    logic [15:0]     data;
    logic            valid, sop, eop;
    logic [CHW-1:0]  ch;
    logic [15:0]     fc;
    logic            busy;

    logic [31:0]     mem [0:1023];
    logic            tb_we = 1'b0;
    logic [9:0]      tb_addr = '0;
    logic [31:0]     tb_wd = '0;

    int cyc = 0;
    int flag_reads = 0, data_reads = 0, writes = 0, bad_wdata = 0;
    int valid_cycles = 0, stall_viol = 0, acc_cyc = 0, rel_cyc = 0;
    logic           stall_prev = 1'b0;
    logic [15:0]    prev_d = '0;
    logic [CHW-1:0] prev_ch = '0;
    logic           prev_sop = 1'b0, prev_eop = 1'b0;
    beat_t          beats[$];
    int             exp_fc = 0;
    bit             done = 1'b0;

    mic_frame_reader #(.MIC_N(N), .ADDR_W(10), .ADDR_LAST(1023)) dut (
      .clk_clk                 (clk),
      .reset_reset_n           (rst_n),
      .irq_in                  (irq),
      .ram_address             (addr),
      .ram_chipselect          (cs),
      .ram_write               (wr),
      .ram_writedata           (wdata),
      .ram_byteenable          (be),
      .ram_readdata            (rdata),
      .av_st_out_data          (data),
      .av_st_out_valid         (valid),
      .av_st_out_ready         (ready),
      .av_st_out_startofpacket (sop),
      .av_st_out_endofpacket   (eop),
      .av_st_out_channel       (ch),
      .frame_count             (fc),
      .busy                    (busy)
    );

    // Single-port RAM with one-cycle read latency; bench preloads through tb_we
    always @(posedge clk) begin
      if (tb_we) mem[tb_addr] <= tb_wd;
      else if (cs && wr) mem[addr] <= wdata;
      if (cs && !wr) rdata <= mem[addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Bus and stream monitor, sampled mid-cycle
    always @(negedge clk) begin
      if (cs && !wr) begin
        if (addr == 10'd1023) flag_reads <= flag_reads + 1;
        else data_reads <= data_reads + 1;
      end
      if (cs && wr) begin
        writes  <= writes + 1;
        rel_cyc <= cyc;
        if (addr != 10'd1023 || wdata != 32'd0) bad_wdata <= bad_wdata + 1;
      end
      if (valid) valid_cycles <= valid_cycles + 1;
      if (valid && ready) begin
        beats.push_back({data, 8'(ch), sop, eop});
        if (eop) acc_cyc <= cyc;
      end
      if (stall_prev && rst_n &&
          (!valid || data != prev_d || ch != prev_ch || sop != prev_sop || eop != prev_eop))
        stall_viol <= stall_viol + 1;
      stall_prev <= valid && !ready && rst_n;
      prev_d     <= data;
      prev_ch    <= ch;
      prev_sop   <= sop;
      prev_eop   <= eop;
    end

    task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
      check($sformatf("n%0d_%s", N, t), got, exp);
    endtask

    task automatic ram_poke(input logic [9:0] a, input logic [31:0] d);
      tb_we = 1'b1; tb_addr = a; tb_wd = d;
      @(posedge clk); #1;
      tb_we = 1'b0;
    endtask

    task automatic load_random();
      for (int k = 0; k < NW; k++) ram_poke(10'(k), $urandom);
      ram_poke(10'd1023, 32'($urandom_range(1, 255)));
    endtask

    // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_frame(input int rmode);
      int fr0, dr0, wr0, sv0, b0, cnt, first_v, nb;
      logic [31:0] word;
      logic [15:0] es;
      beat_t bt;
      fr0 = flag_reads; dr0 = data_reads; wr0 = writes; sv0 = stall_viol; b0 = beats.size();
      irq = 1'b1; ready = 1'b1; cnt = 0; first_v = -1;
      do begin
        @(posedge clk); #1;
        cnt++;
        irq = 1'b0;
        if (rmode == 1) ready = (cnt % 4 == 0) || (cnt % 4 == 3);
        else if (rmode == 2) ready = ($urandom_range(0, 2) != 0);
        if (valid && first_v < 0) first_v = cnt;
      end while (busy && cnt < 400);
      exp_fc = (exp_fc + 1) % 65536;
      chk("frame_timeout", 32'(busy), 32'd0);
      chk("first_valid_cycle", 32'(first_v), 32'd5);
      if (rmode == 0) chk("frame_cycles", 32'(cnt), 32'(5 + 4 * NW - (N % 2)));
      nb = beats.size() - b0;
      chk("beat_count", 32'(nb), 32'(N));
      for (int m = 0; m < N && m < nb; m++) begin
        word = mem[m / 2];
        es = (m % 2 == 1) ? word[31:16] : word[15:0];
        bt = beats[b0 + m];
        chk($sformatf("beat%0d_data", m), 32'(bt.d), 32'(es));
        chk($sformatf("beat%0d_channel", m), 32'(bt.ch), 32'(m));
        chk($sformatf("beat%0d_sop", m), 32'(bt.sop), 32'(m == 0));
        chk($sformatf("beat%0d_eop", m), 32'(bt.eop), 32'(m == N - 1));
      end
      chk("flag_reads", 32'(flag_reads - fr0), 32'd1);
      chk("data_reads", 32'(data_reads - dr0), 32'(NW));
      chk("writes", 32'(writes - wr0), 32'd1);
      chk("bad_write", 32'(bad_wdata), 32'd0);
      chk("flag_cleared", mem[1023], 32'd0);
      chk("release_after_accept", 32'(rel_cyc), 32'(acc_cyc + 1));
      chk("stall_stable", 32'(stall_viol - sv0), 32'd0);
      chk("frame_count", 32'(fc), 32'(exp_fc));
      chk("byteenable", 32'(be), 32'hF);
      $display("n=%0d frame mode=%0d beats=%0d cycles=%0d frame_count=%0d", N, rmode, nb, cnt, fc);
    endtask

    task automatic spurious();
      int fr0, dr0, wr0, vc0, b0, cnt;
      ram_poke(10'd1023, 32'd0);
      fr0 = flag_reads; dr0 = data_reads; wr0 = writes; vc0 = valid_cycles; b0 = beats.size();
      irq = 1'b1; ready = 1'b1; cnt = 0;
      do begin
        @(posedge clk); #1;
        cnt++;
        irq = 1'b0;
      end while (busy && cnt < 20);
      chk("spur_cycles", 32'(cnt), 32'd3);
      chk("spur_flag_reads", 32'(flag_reads - fr0), 32'd1);
      chk("spur_data_reads", 32'(data_reads - dr0), 32'd0);
      chk("spur_writes", 32'(writes - wr0), 32'd0);
      chk("spur_valid", 32'(valid_cycles - vc0), 32'd0);
      chk("spur_beats", 32'(beats.size() - b0), 32'd0);
      chk("spur_frame_count", 32'(fc), 32'(exp_fc));
      $display("n=%0d spurious irq cycles=%0d frame_count=%0d", N, cnt, fc);
    endtask

    task automatic reset_mid_frame();
      int wr0, cnt;
      bit hit;
      load_random();
      wr0 = writes; irq = 1'b1; ready = 1'b1; cnt = 0; hit = 1'b0;
      do begin
        @(posedge clk); #1;
        cnt++;
        irq = 1'b0;
        hit = valid && (ch == CHW'(1));
      end while (!hit && cnt < 50);
      chk("reach_emit_hi", 32'(hit), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 32'({valid, cs, wr, sop, eop, busy}), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      chk("midrst_data", 32'(data), 32'd0);
      chk("midrst_channel", 32'(ch), 32'd0);
      chk("midrst_frame_count", 32'(fc), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_fc = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_no_release", 32'(writes - wr0), 32'd0);
      chk("midrst_flag_kept", mem[1023] == 32'd0 ? 32'd0 : 32'd1, 32'd1);
      chk("midrst_idle", 32'(busy), 32'd0);
      $display("n=%0d reset during EMIT_HI at cycle %0d", N, cnt);
    endtask

    initial begin
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({valid, cs, wr, sop, eop, busy}), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_frame_count", 32'(fc), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      if (N == 2) begin
        ram_poke(10'd0, 32'hBEEF_1234);
      end else if (N == 3) begin
        ram_poke(10'd0, 32'h0002_0001);
        ram_poke(10'd1, 32'hFFFF_0003);
      end else begin
        for (int k = 0; k < NW; k++) ram_poke(10'(k), $urandom);
      end
      ram_poke(10'd1023, 32'd1);
      run_frame(0);

      spurious();

      load_random();
      run_frame(1);

      for (int f = 0; f < 6; f++) begin
        load_random();
        run_frame(int'($urandom_range(0, 2)));
      end

      reset_mid_frame();
      run_frame(0);

      done = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      if (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) break;
      @(posedge clk);
    end
    if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
      check("global_timeout", 32'd0, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mic_frame_reader.md
# mic_frame_reader

Consumer side of the microphone-frame mailbox in the shared on-chip RAM (port s2). When the frame producer raises its interrupt line, this block confirms the flag word at the last RAM address. It then reads the packed 16-bit PCM words for all microphones and emits them one sample per beat on an Avalon-ST source. Finally it writes 0 to the flag word, which releases the producer. It is the hardware counterpart of the Nios software consumer and is used for hardware-only data paths and loopback verification.

## Interface
- MIC_N, 2, number of microphones (samples per frame), 1..2046
- ADDR_W, 10, RAM word-address width
- ADDR_LAST, 1023, mailbox flag word address
- clk_clk  in  1  system clock (same clock as the RAM s2 port and the producer)
- reset_reset_n  in  1  reset; asynchronous, active-low
- irq_in  in  1  level interrupt from the frame producer
- ram_address  out  ADDR_W  RAM word address
- ram_chipselect  out  1  RAM access strobe
- ram_write  out  1  1 = write, 0 = read
- ram_writedata  out  32  write data
- ram_byteenable  out  4  constant 4'b1111
- ram_readdata  in  32  read data, valid 1 cycle after a read strobe
- av_st_out_data  out  16  PCM sample
- av_st_out_valid  out  1  sample valid
- av_st_out_ready  in  1  sink ready
- av_st_out_startofpacket  out  1  first sample of frame (mic 0)
- av_st_out_endofpacket  out  1  last sample of frame (mic MIC_N-1)
- av_st_out_channel  out  clog2(MIC_N) or 1, whichever is larger  microphone index of current sample
- frame_count  out  16  frames completed, wraps 65535 -> 0
- busy  out  1  high whenever state != IDLE

## Operation
- All outputs reset to 0, address reset to 0, state reset to IDLE.
- Frame layout: words 0..W-1 with W = ceil(MIC_N/2). Word k[15:0] = mic 2k and word k[31:16] = mic 2k+1. If MIC_N is odd, the upper half of word W-1 is ignored.
- FSM states: IDLE, POLL_REQ, POLL_CHK, RD_REQ, RD_CAP, EMIT_LO, EMIT_HI, RELEASE, DONE.
- IDLE: if irq_in = 1, go to POLL_REQ.
- POLL_REQ: drive ram_address = ADDR_LAST, chipselect = 1, write = 0. Go to POLL_CHK.
- POLL_CHK: sample ram_readdata.
  - If 0, the interrupt is spurious; go to IDLE. No output and no release.
  - Otherwise set word index = 0 and go to RD_REQ.
- RD_REQ: read at address = word index. Go to RD_CAP.
- RD_CAP: latch ram_readdata into a 32-bit holding register. Go to EMIT_LO.
- EMIT_LO: valid = 1, data = hold[15:0], channel = 2·index.
  - Stay until ready = 1.
  - On acceptance: if 2·index+1 == MIC_N, go to RELEASE; otherwise go to EMIT_HI.
- EMIT_HI: valid = 1, data = hold[31:16], channel = 2·index+1.
  - Stay until ready = 1.
  - On acceptance: if index == W-1, go to RELEASE; otherwise increment index and go to RD_REQ.
- RELEASE: write 32'd0 to ADDR_LAST (chipselect = 1, write = 1). Go to DONE.
- DONE: increment frame_count. Go to IDLE.
- startofpacket = 1 only on the beat with channel 0. endofpacket = 1 only on the beat with channel MIC_N-1.
- Data, channel, sop and eop are held stable while valid = 1 and ready = 0. Valid never drops before acceptance.
- irq_in is sampled only in IDLE. Changes in irq_in during a frame are ignored.
- chipselect and write are combinational decodes of state. address and writedata are registered.

## Timing
- irq_in rising edge seen in IDLE at cycle 0:
  - read strobe in cycle 1 (POLL_REQ);
  - flag checked in cycle 2;
  - first word read in cycle 3;
  - first valid sample in cycle 5.
- With ready held at 1:
  - each word costs 4 cycles (RD_REQ, RD_CAP, EMIT_LO, EMIT_HI);
  - the frame takes 3 + 4·W + 2 cycles from irq to return to IDLE, shorter by 1 cycle for odd MIC_N.
- Release write occurs exactly 1 cycle after acceptance of the last sample.
- Because the RAM read latency is 1 cycle, readdata is sampled only in POLL_CHK and RD_CAP.
- Reset asserted mid-frame:
  - immediate return to IDLE with all outputs 0;
  - no release write is issued, so the producer stays blocked until the next irq and poll;
  - frame_count is not incremented.
- Back-to-back frames: if irq_in is still 1 in IDLE after DONE, a new poll starts. If the producer has not yet re-armed, the flag reads 0 and the interrupt is treated as spurious.

## Test plan
- MIC_N = 2; RAM word 0 = 32'hBEEF_1234, flag = 1; pulse irq with ready held at 1.
  - Beats required: 16'h1234 (ch 0, sop), then 16'hBEEF (ch 1, eop).
  - Then a write of 0 to 1023; frame_count = 1; first valid at cycle 5.
- MIC_N = 3; words 0 and 1 = 32'h0002_0001 and 32'hFFFF_0003.
  - Beats required: 1, 2, 3, with eop on ch 2.
  - 16'hFFFF is never emitted; exactly 2 data reads occur.
- Backpressure: MIC_N = 4; ready toggles 1, 0, 0, 1 …
  - Data and channel are stable during stalls.
  - Beat count is 4 and there is no duplicate or dropped sample.
- Spurious irq: flag = 0 and irq = 1.
  - Exactly one read of address 1023, then return to IDLE.
  - No valid, no write, frame_count unchanged.
- Reset during EMIT_HI of word 0: assert reset_reset_n = 0 for 2 cycles.
  - All outputs are 0 and no write to 1023 occurs.
  - A later irq with flag = 1 completes a full frame.
